// File: rtl/ncl_wavefront_sequencer.sv
// ncl_wavefront_sequencer
// Clocked controller driving a combinational dual-rail NCL datapath from a
// single-rail valid/ready operand stream. Each operand pair is encoded as DATA
// on the dual-rail inputs. The controller waits for the datapath output to
// become complete, returns the result, then drives NULL and waits for the
// output to clear before it accepts the next operand pair.
//
// Optional build macro: NCL_SEQ_TIMEOUT_EN
//   defined   : both wait states give up after TIMEOUT cycles and set the
//               sticky timeout_err flag.
//   undefined : wait states wait indefinitely and timeout_err is tied low.
module ncl_wavefront_sequencer #(
    parameter int WIDTH      = 4,
    parameter int SETTLE_MIN = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] dr_a_t,
    output logic [WIDTH-1:0] dr_a_f,
    output logic [WIDTH-1:0] dr_b_t,
    output logic [WIDTH-1:0] dr_b_f,
    input  logic [WIDTH-1:0] dr_out_t,
    input  logic [WIDTH-1:0] dr_out_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             illegal,
    output logic             timeout_err
);

    // The wait counter only has to reach the timeout limit when timeouts are
    // built in; otherwise it only has to reach the settle threshold.
    // TIMEOUT carries zero weight in the timeout-free build so that the
    // parameter stays referenced.
`ifdef NCL_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
`else
    localparam int CNT_W = $clog2(SETTLE_MIN + 1) + 0 * TIMEOUT;
`endif

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_MIN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
`ifdef NCL_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
`endif

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] DATA_WAIT = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] NULL_WAIT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_step;
    logic [WIDTH-1:0] dr_a_t_q, dr_a_t_d;
    logic [WIDTH-1:0] dr_a_f_q, dr_a_f_d;
    logic [WIDTH-1:0] dr_b_t_q, dr_b_t_d;
    logic [WIDTH-1:0] dr_b_f_q, dr_b_f_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             illegal_q, illegal_d;
`ifdef NCL_SEQ_TIMEOUT_EN
    logic             timeout_err_q, timeout_err_d;
`endif

    logic complete_data;
    logic complete_null;
    logic rail_clash;
    logic settled;

    // Datapath completion detection: every pair exactly one-hot means DATA
    // has arrived; every rail low means the wavefront has returned to NULL.
    // Both rails high on any bit is an illegal code.
    assign complete_data = &(dr_out_t ^ dr_out_f);
    assign complete_null = ~|(dr_out_t | dr_out_f);
    assign rail_clash    = |(dr_out_t & dr_out_f);
    assign settled       = (cnt_q >= SETTLE_LAST);
    assign cnt_step      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign busy      = (state_q != IDLE);
    assign dr_a_t    = dr_a_t_q;
    assign dr_a_f    = dr_a_f_q;
    assign dr_b_t    = dr_b_t_q;
    assign dr_b_f    = dr_b_f_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign illegal   = illegal_q;
`ifdef NCL_SEQ_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Next-state logic for the DATA/NULL wavefront cycle and its bookkeeping
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dr_a_t_d    = dr_a_t_q;
        dr_a_f_d    = dr_a_f_q;
        dr_b_t_d    = dr_b_t_q;
        dr_b_f_d    = dr_b_f_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        illegal_d   = illegal_q | rail_clash;
`ifdef NCL_SEQ_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    dr_a_t_d = in_a;
                    dr_a_f_d = ~in_a;
                    dr_b_t_d = in_b;
                    dr_b_f_d = ~in_b;
                    cnt_d    = '0;
                    state_d  = DATA_WAIT;
                end
            end

            DATA_WAIT: begin
                cnt_d = cnt_step;
                if (complete_data && settled) begin
                    out_data_d  = dr_out_t;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
`ifdef NCL_SEQ_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    dr_a_t_d      = '0;
                    dr_a_f_d      = '0;
                    dr_b_t_d      = '0;
                    dr_b_f_d      = '0;
                    cnt_d         = '0;
                    state_d       = NULL_WAIT;
                end
`endif
            end

            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    dr_a_t_d    = '0;
                    dr_a_f_d    = '0;
                    dr_b_t_d    = '0;
                    dr_b_f_d    = '0;
                    cnt_d       = '0;
                    state_d     = NULL_WAIT;
                end
            end

            NULL_WAIT: begin
                cnt_d = cnt_step;
                if (complete_null && settled) begin
                    state_d = IDLE;
                end
`ifdef NCL_SEQ_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
`endif
            end

            default: begin
                dr_a_t_d    = '0;
                dr_a_f_d    = '0;
                dr_b_t_d    = '0;
                dr_b_f_d    = '0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State registers; reset forces NULL on every rail and discards any result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dr_a_t_q    <= '0;
            dr_a_f_q    <= '0;
            dr_b_t_q    <= '0;
            dr_b_f_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            illegal_q   <= 1'b0;
`ifdef NCL_SEQ_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dr_a_t_q    <= dr_a_t_d;
            dr_a_f_q    <= dr_a_f_d;
            dr_b_t_q    <= dr_b_t_d;
            dr_b_f_q    <= dr_b_f_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            illegal_q   <= illegal_d;
`ifdef NCL_SEQ_TIMEOUT_EN
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ncl_wavefront_sequencer.sv
// tb_ncl_wavefront_sequencer
// Scoreboard bench for ncl_wavefront_sequencer. A behavioural model of four
// NCL_xor cells stands in for the datapath. It can delay completion of bit 3,
// hold its output at NULL, or drive an illegal code on bit 0. Each accepted
// operand pair pushes a ^ b and its accept cycle into a queue. A monitor pops
// the queue when out_valid rises and checks the data and the latencies.
module tb_ncl_wavefront_sequencer;

    localparam int WIDTH      = 4;
    localparam int SETTLE_MIN = 2;
    localparam int TIMEOUT    = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [WIDTH-1:0] dr_a_t, dr_a_f, dr_b_t, dr_b_f;
    logic [WIDTH-1:0] dr_out_t, dr_out_f;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             illegal;
    logic             timeout_err;

    logic out_ready_main = 1'b0;
    logic rand_en = 1'b0;
    logic rand_bit = 1'b0;
    assign out_ready = rand_en ? rand_bit : out_ready_main;

    int   dp_mode = 0;
    logic force_illegal = 1'b0;
    int   data_age;
    logic [WIDTH-1:0] xt, xf;

    int n_checks = 0;
    int n_fail = 0;
    int cycle = 0;
    int last_acc = 0;
    logic ideal = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        int               acc_cycle;
    } exp_t;
    exp_t sb_q[$];

    ncl_wavefront_sequencer #(
        .WIDTH(WIDTH),
        .SETTLE_MIN(SETTLE_MIN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .dr_a_t(dr_a_t),
        .dr_a_f(dr_a_f),
        .dr_b_t(dr_b_t),
        .dr_b_f(dr_b_f),
        .dr_out_t(dr_out_t),
        .dr_out_f(dr_out_f),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .busy(busy),
        .illegal(illegal),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to measure latencies
    always @(posedge clk) cycle <= cycle + 1;

    // Random consumer stall pattern, changed well away from both clock edges
    always @(posedge clk) begin
        #2 rand_bit = 1'($urandom_range(0, 1));
    end

    // Number of edges the datapath inputs have carried DATA
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_age <= 0;
        else if ((dr_a_t | dr_a_f | dr_b_t | dr_b_f) == '0) data_age <= 0;
        else data_age <= data_age + 1;
    end

    // Datapath: four NCL_xor cells with optional slow bit, stuck NULL or illegal code
    always_comb begin
        xt = '0;
        xf = '0;
        for (int i = 0; i < WIDTH; i++) begin
            xt[i] = (dr_a_t[i] & dr_b_f[i]) | (dr_a_f[i] & dr_b_t[i]);
            xf[i] = (dr_a_t[i] & dr_b_t[i]) | (dr_a_f[i] & dr_b_f[i]);
        end
        if (dp_mode == 1 && data_age < 6) begin
            xt[3] = 1'b0;
            xf[3] = 1'b0;
        end
        if (dp_mode == 2) begin
            xt = '0;
            xf = '0;
        end
        if (force_illegal) begin
            xt[0] = 1'b1;
            xf[0] = 1'b1;
        end
        dr_out_t = xt;
        dr_out_f = xf;
    end

    // One comparison: count it, report a failure with both values
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present one operand pair until accepted; optionally record the expected result
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
        int guard;
        logic sampled;
        guard = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        forever begin
            sampled = in_ready;
            @(posedge clk);
            if (sampled) break;
            #1;
            guard++;
            if (guard > 300) begin
                checkOutput("accept_wait_expired", 1, 0);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        last_acc = cycle;
        if (push) sb_q.push_back('{data: a ^ b, acc_cycle: cycle});
    endtask

    // Wait until the sequencer returns to idle, bounded
    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) checkOutput("idle_wait_expired", 1, 0);
    endtask

    // Wait until a result is presented, bounded
    task automatic waitValid(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) checkOutput("valid_wait_expired", 1, 0);
    endtask

    // Scoreboard monitor: pops on each new result, checks data, stability and latency
    exp_t cur;
    logic have_cur = 1'b0;
    logic ov_prev = 1'b0;
    logic hs_pending = 1'b0;
    int   hs_cycle = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("in_ready_out_valid_exclusive", 32'(in_ready & out_valid), 0);
            if (out_valid && !ov_prev) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1'b1;
                    checkOutput("out_data", 32'(out_data), 32'(cur.data));
                    if (ideal) checkOutput("accept_to_valid_latency", cycle - cur.acc_cycle, 2);
                end
            end else if (out_valid && have_cur) begin
                checkOutput("out_data_stable", 32'(out_data), 32'(cur.data));
            end
            if (in_ready && hs_pending) begin
                if (ideal) checkOutput("handshake_to_ready_latency", cycle - hs_cycle, 2);
                hs_pending = 1'b0;
            end
            if (out_valid && out_ready) begin
                hs_cycle = cycle + 1;
                hs_pending = 1'b1;
                have_cur = 1'b0;
            end
        end else begin
            hs_pending = 1'b0;
            have_cur = 1'b0;
        end
        ov_prev = out_valid;
    end

    // Global runaway guard
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_out_data", 32'(out_data), 0);
        checkOutput("reset_illegal", 32'(illegal), 0);
        checkOutput("reset_timeout_err", 32'(timeout_err), 0);
        checkOutput("reset_rails_null", 32'({dr_a_t, dr_a_f, dr_b_t, dr_b_f}), 0);
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready", 32'(in_ready), 1);

        // Basic operation, then every operand pair with an always-ready consumer
        out_ready_main = 1'b1;
        applyStimulus(4'b0011, 4'b0101, 1'b1);
        waitIdle(50);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus(4'(a), 4'(b), 1'b1);
            end
        end
        waitIdle(50);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        // Result held stable under consumer stall; operand pulses ignored
        out_ready_main = 1'b0;
        applyStimulus(4'b0011, 4'b0101, 1'b1);
        @(posedge clk);
        #1;
        waitValid(20);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            in_a = 4'($urandom);
            in_b = 4'($urandom);
            checkOutput("hold_out_valid", 32'(out_valid), 1);
            checkOutput("hold_out_data", 32'(out_data), 32'(4'b0110));
            checkOutput("hold_dr_a_t", 32'(dr_a_t), 32'(4'b0011));
            checkOutput("hold_dr_b_t", 32'(dr_b_t), 32'(4'b0101));
            checkOutput("hold_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready_main = 1'b1;
        waitIdle(50);

        // Slow bit 3: result only after it completes
        dp_mode = 1;
        ideal = 1'b0;
        applyStimulus(4'b1010, 4'b0110, 1'b1);
        waitValid(40);
        checkOutput("slow_bit3_latency", cycle - last_acc, 7);
        waitIdle(50);
        dp_mode = 0;
        ideal = 1'b1;

        // Illegal rail code on bit 0 for one cycle: sticky until reset
        @(posedge clk);
        #1;
        checkOutput("illegal_before", 32'(illegal), 0);
        force_illegal = 1'b1;
        @(posedge clk);
        #1;
        force_illegal = 1'b0;
        checkOutput("illegal_set", 32'(illegal), 1);
        applyStimulus(4'hF, 4'h0, 1'b1);
        waitIdle(50);
        checkOutput("illegal_sticky", 32'(illegal), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("illegal_cleared_by_reset", 32'(illegal), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-DATA_WAIT: rails NULL at once, handshake idle
        dp_mode = 2;
        applyStimulus(4'b1100, 4'b0110, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("data_wait_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_rails_null", 32'({dr_a_t, dr_a_f, dr_b_t, dr_b_f}), 0);
        checkOutput("abort_out_valid", 32'(out_valid), 0);
        checkOutput("abort_in_ready", 32'(in_ready), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("abort_release_in_ready", 32'(in_ready), 1);
        dp_mode = 0;

        // Reset mid-HOLD discards the pending result
        out_ready_main = 1'b0;
        applyStimulus(4'b0001, 4'b0111, 1'b1);
        waitValid(20);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("hold_abort_out_valid", 32'(out_valid), 0);
        checkOutput("hold_abort_out_data", 32'(out_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready_main = 1'b1;

        // Datapath stuck at NULL after DATA is issued
        dp_mode = 2;
        applyStimulus(4'b0101, 4'b1001, 1'b0);
`ifdef NCL_SEQ_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (!timeout_err && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        checkOutput("timeout_cycle", cycle - last_acc, 16);
        checkOutput("timeout_err_set", 32'(timeout_err), 1);
        checkOutput("timeout_rails_null", 32'({dr_a_t, dr_a_f, dr_b_t, dr_b_f}), 0);
        checkOutput("timeout_no_out_valid", 32'(out_valid), 0);
        waitIdle(30);
        checkOutput("timeout_back_idle", 32'(busy), 0);
        checkOutput("timeout_err_sticky", 32'(timeout_err), 1);
`else
        repeat (30) @(posedge clk);
        #1;
        checkOutput("stuck_busy", 32'(busy), 1);
        checkOutput("stuck_timeout_err", 32'(timeout_err), 0);
        checkOutput("stuck_out_valid", 32'(out_valid), 0);
        checkOutput("stuck_dr_a_t", 32'(dr_a_t), 32'(4'b0101));
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif
        dp_mode = 0;

        // Randomized operands with a randomly stalling consumer
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'($urandom), 4'($urandom), 1'b1);
        end
        waitIdle(300);
        rand_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("final_scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
